// File: rtl/int_ctrl_if.sv
// Pipeline-status interrupt handshake bundle between the interrupt controller
// (slave) and the pipeline/PC logic or its model (master).
interface int_ctrl_if #(
  parameter int N_IRQ = 8
);
  localparam int CAUSE_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0]   irq;
  logic               int_enable;
  logic               mask_we;
  logic [N_IRQ-1:0]   mask_wdata;
  logic               branch_pending;
  logic               iret;
  logic [31:0]        epc_in;
  logic               int_set_pl_pause;
  logic               int_flag;
  logic [31:0]        int_pc;
  logic               in_service;
  logic [CAUSE_W-1:0] cause;
  logic [31:0]        epc_out;
  logic [N_IRQ-1:0]   pending;

  modport slave (
    input  irq, int_enable, mask_we, mask_wdata, branch_pending, iret, epc_in,
    output int_set_pl_pause, int_flag, int_pc, in_service, cause, epc_out, pending
  );

  modport master (
    output irq, int_enable, mask_we, mask_wdata, branch_pending, iret, epc_in,
    input  int_set_pl_pause, int_flag, int_pc, in_service, cause, epc_out, pending
  );
endinterface

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller: pauses the pipeline, redirects to the
// vector of the lowest-index eligible IRQ, and redirects back on iret.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for an enabled, eligible, unblocked request
//   S_PAUSE   | pause held for DRAIN_CYCLES cycles while the pipe drains
//   S_FIRE    | int_flag pulse, int_pc = vector of cause
//   S_SERVICE | handler running, no nesting, waiting for iret
//   S_RETURN  | int_flag pulse, int_pc = saved epc
module int_ctrl #(
  parameter int          N_IRQ        = 8,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
  input  logic      clk,
  input  logic      clr,
  int_ctrl_if.slave bus
);
  localparam int CAUSE_W = $clog2(N_IRQ);
  localparam int CNT_W   = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_FIRE, S_SERVICE, S_RETURN
  } state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   irq_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        pc_q, pc_d;
  logic               pause_q, flag_q, svc_q;
  logic [N_IRQ-1:0]   eligible;
  logic [CAUSE_W-1:0] winner;

  always_comb begin
    eligible  = pending_q & mask_q;
    winner    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CAUSE_W'(i);
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    pc_d      = pc_q;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

    // Clear of the serviced line comes first so a fresh edge in FIRE survives.
    pending_d = pending_q;
    if (state_q == S_FIRE) pending_d[cause_q] = 1'b0;
    pending_d = pending_d | (bus.irq & ~irq_q);

    case (state_q)
      S_IDLE: begin
        if (bus.int_enable && (|eligible) && !bus.branch_pending) begin
          state_d = S_PAUSE;
          cause_d = winner;
          cnt_d   = '0;
        end
      end
      S_PAUSE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_FIRE;
          epc_d   = bus.epc_in;
          pc_d    = VEC_BASE + 32'(cause_q) * VEC_STRIDE;
        end
      end
      S_FIRE:    state_d = S_SERVICE;
      S_SERVICE: begin
        if (bus.iret) begin
          state_d = S_RETURN;
          pc_d    = epc_q;
        end
      end
      S_RETURN:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      pc_q      <= '0;
      pause_q   <= 1'b0;
      flag_q    <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= bus.irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      pc_q      <= pc_d;
      pause_q   <= (state_d == S_PAUSE);
      flag_q    <= (state_d == S_FIRE) || (state_d == S_RETURN);
      svc_q     <= (state_d == S_SERVICE);
    end
  end

  assign bus.int_set_pl_pause = pause_q;
  assign bus.int_flag         = flag_q;
  assign bus.int_pc           = pc_q;
  assign bus.in_service       = svc_q;
  assign bus.cause            = cause_q;
  assign bus.epc_out          = epc_q;
  assign bus.pending          = pending_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: entry timing, priority, return, gating,
// FIRE-cycle edge retention, committed pause and async reset.
module tb_int_ctrl;
  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;

  int_ctrl_if #(.N_IRQ(8)) bus ();

  int_ctrl #(
    .N_IRQ(8), .DRAIN_CYCLES(3),
    .VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first observed PAUSE cycle; returns in the first SERVICE cycle.
  task automatic expect_pause_fire(input string tag, input logic [31:0] pc,
                                   input logic [31:0] cause, input logic [31:0] epc);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_pause"}, 32'(bus.int_set_pl_pause), 32'd1);
      check({tag, "_noflag"}, 32'(bus.int_flag), 32'd0);
      tick();
    end
    check({tag, "_fire_pause"}, 32'(bus.int_set_pl_pause), 32'd0);
    check({tag, "_fire_flag"}, 32'(bus.int_flag), 32'd1);
    check({tag, "_fire_pc"}, bus.int_pc, pc);
    check({tag, "_cause"}, 32'(bus.cause), cause);
    check({tag, "_epc"}, bus.epc_out, epc);
    tick();
    check({tag, "_svc"}, 32'(bus.in_service), 32'd1);
    check({tag, "_svc_flag"}, 32'(bus.int_flag), 32'd0);
  endtask

  // Called in SERVICE; returns in the IDLE cycle after RETURN.
  task automatic do_iret(input string tag, input logic [31:0] pc);
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check({tag, "_ret_flag"}, 32'(bus.int_flag), 32'd1);
    check({tag, "_ret_pc"}, bus.int_pc, pc);
    check({tag, "_ret_svc"}, 32'(bus.in_service), 32'd0);
    tick();
    check({tag, "_idle_flag"}, 32'(bus.int_flag), 32'd0);
    check({tag, "_pc_held"}, bus.int_pc, pc);
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr = 1'b1;
    bus.irq = '0;
    bus.int_enable = 1'b0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;
    bus.branch_pending = 1'b0;
    bus.iret = 1'b0;
    bus.epc_in = '0;

    #3;
    check("rst_pause", 32'(bus.int_set_pl_pause), 32'd0);
    check("rst_flag", 32'(bus.int_flag), 32'd0);
    check("rst_pc", bus.int_pc, 32'd0);
    check("rst_svc", 32'(bus.in_service), 32'd0);
    check("rst_cause", 32'(bus.cause), 32'd0);
    check("rst_epc", bus.epc_out, 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    tick();
    clr = 1'b0;

    // Basic entry
    bus.int_enable = 1'b1;
    bus.epc_in = 32'h40;
    write_mask(8'hFF);
    bus.irq[2] = 1'b1;
    tick();
    check("basic_pending", 32'(bus.pending), 32'h04);
    check("basic_nopause", 32'(bus.int_set_pl_pause), 32'd0);
    tick();
    expect_pause_fire("basic", 32'h120, 32'd2, 32'h40);
    check("basic_clr_pend", 32'(bus.pending), 32'h00);
    bus.irq = '0;
    do_iret("basic", 32'h40);

    // iret outside SERVICE is ignored
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check("idle_iret_flag", 32'(bus.int_flag), 32'd0);
    tick();
    check("idle_iret_flag2", 32'(bus.int_flag), 32'd0);

    // Priority: lines 5 and 1 together
    bus.epc_in = 32'h80;
    bus.irq = 8'h22;
    tick();
    check("pri_pending", 32'(bus.pending), 32'h22);
    tick();
    expect_pause_fire("pri1", 32'h110, 32'd1, 32'h80);
    check("pri_keep5", 32'(bus.pending), 32'h20);
    bus.irq = '0;
    do_iret("pri1", 32'h80);
    tick();
    expect_pause_fire("pri5", 32'h150, 32'd5, 32'h80);
    do_iret("pri5", 32'h80);

    // Mask gating
    bus.epc_in = 32'h200;
    write_mask(8'h00);
    bus.irq[3] = 1'b1;
    tick();
    check("mask_pending", 32'(bus.pending), 32'h08);
    tick();
    tick();
    check("mask_nopause", 32'(bus.int_set_pl_pause), 32'd0);
    write_mask(8'h08);
    check("mask_wr_nopause", 32'(bus.int_set_pl_pause), 32'd0);
    check("mask_keeps_pend", 32'(bus.pending), 32'h08);
    tick();
    expect_pause_fire("mask3", 32'h130, 32'd3, 32'h200);
    bus.irq = '0;
    do_iret("mask3", 32'h200);

    // branch_pending blocks entry
    write_mask(8'hFF);
    bus.branch_pending = 1'b1;
    bus.irq[4] = 1'b1;
    tick();
    tick();
    tick();
    check("bp_nopause", 32'(bus.int_set_pl_pause), 32'd0);
    bus.branch_pending = 1'b0;
    tick();
    expect_pause_fire("bp4", 32'h140, 32'd4, 32'h200);
    bus.irq = '0;
    do_iret("bp4", 32'h200);

    // int_enable low blocks entry
    bus.int_enable = 1'b0;
    bus.irq[6] = 1'b1;
    tick();
    tick();
    tick();
    check("en_nopause", 32'(bus.int_set_pl_pause), 32'd0);
    bus.int_enable = 1'b1;
    tick();
    expect_pause_fire("en6", 32'h160, 32'd6, 32'h200);
    bus.irq = '0;
    do_iret("en6", 32'h200);

    // New edge on the serviced line during FIRE is kept
    bus.epc_in = 32'h300;
    bus.irq[2] = 1'b1;
    tick();
    bus.irq[2] = 1'b0;
    tick();
    check("fe_pause", 32'(bus.int_set_pl_pause), 32'd1);
    tick();
    tick();
    tick();
    check("fe_fire", 32'(bus.int_flag), 32'd1);
    bus.irq[2] = 1'b1;
    tick();
    check("fe_pend_kept", 32'(bus.pending), 32'h04);
    check("fe_svc", 32'(bus.in_service), 32'd1);
    bus.irq = '0;
    do_iret("fe", 32'h300);
    tick();
    expect_pause_fire("fe2", 32'h120, 32'd2, 32'h300);
    do_iret("fe2", 32'h300);

    // int_enable dropped mid-PAUSE does not abort
    bus.irq[7] = 1'b1;
    tick();
    bus.irq = '0;
    tick();
    check("drop_pause1", 32'(bus.int_set_pl_pause), 32'd1);
    bus.int_enable = 1'b0;
    tick();
    tick();
    check("drop_pause3", 32'(bus.int_set_pl_pause), 32'd1);
    tick();
    check("drop_fire", 32'(bus.int_flag), 32'd1);
    check("drop_pc", bus.int_pc, 32'h170);
    tick();
    check("drop_svc", 32'(bus.in_service), 32'd1);
    bus.int_enable = 1'b1;
    do_iret("drop", 32'h300);

    // Async reset during PAUSE
    bus.irq[0] = 1'b1;
    tick();
    bus.irq = '0;
    tick();
    check("rstp_pause", 32'(bus.int_set_pl_pause), 32'd1);
    #2;
    clr = 1'b1;
    #1;
    check("rstp_async_pause", 32'(bus.int_set_pl_pause), 32'd0);
    check("rstp_flag", 32'(bus.int_flag), 32'd0);
    check("rstp_pending", 32'(bus.pending), 32'd0);
    check("rstp_pc", bus.int_pc, 32'd0);
    tick();
    clr = 1'b0;
    tick();
    tick();
    check("rstp_idle", 32'(bus.int_set_pl_pause), 32'd0);
    check("rstp_svc", 32'(bus.in_service), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller that drives the pipeline-status interrupt handshake.
- Collects edge-triggered IRQ lines, masks them and selects the highest-priority one.
- Requests a pipeline pause, then fires `int_flag` with the vector address as `int_pc`.
- On `iret` it fires `int_flag` again with the saved return PC. It sits beside the pipeline-status/PC logic and is the producer of `int_set_pl_pause`, `int_flag` and `int_pc`.

Parameters:
- N_IRQ, 8, number of interrupt lines (2..32).
- DRAIN_CYCLES, 3, cycles `int_set_pl_pause` is held before firing (>=1).
- VEC_BASE, 32'h0000_0100, address of vector 0.
- VEC_STRIDE, 32'h0000_0010, byte distance between consecutive vectors.

Ports:
- clk  input  1  clock, all state updates on posedge.
- clr  input  1  asynchronous active-high reset.
- irq  input  N_IRQ  interrupt request lines; a rising edge requests.
- int_enable  input  1  global interrupt enable.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  N_IRQ  new mask value; bit=1 enables the line.
- branch_pending  input  1  branch or redirect in flight; blocks interrupt entry.
- iret  input  1  one-cycle pulse when a return-from-interrupt is decoded.
- epc_in  input  32  PC of the oldest unretired instruction (the resume address).
- int_set_pl_pause  output  1  pipeline pause request.
- int_flag  output  1  one-cycle redirect pulse.
- int_pc  output  32  redirect target for `int_flag`.
- in_service  output  1  handler is executing.
- cause  output  $clog2(N_IRQ)  index of the accepted IRQ.
- epc_out  output  32  saved resume address.
- pending  output  N_IRQ  pending register, exposed for status reads.

Behaviour:
- Reset (`clr`=1, async): all of the following are 0 — outputs, `pending`, mask, `irq_q`, counter, `int_pc`, `epc_out`, `cause`. FSM goes to IDLE.
- Edge detect:
  - `irq_q <= irq` each cycle.
  - `pending[i]` sets when `irq[i] & ~irq_q[i]`.
  - `pending[cause]` clears in the FIRE cycle. If a new edge on the same line arrives in that cycle, set wins.
- Mask: on `mask_we`, mask <= `mask_wdata` (next cycle). Writing the mask never clears `pending`.
- Eligible = `pending & mask`. Priority: lowest index wins.
- FSM, one state per cycle unless noted:
  - IDLE: if `int_enable` && `|eligible` && `!branch_pending` -> PAUSE. On this transition latch `cause` = winner and clear the counter.
  - PAUSE:
    - `int_set_pl_pause`=1; counter increments each cycle.
    - When counter==DRAIN_CYCLES-1: capture `epc_out` <= `epc_in` and go to FIRE.
    - PAUSE is committed: changes to `int_enable`, mask or `branch_pending` do not abort it. Duration is exactly DRAIN_CYCLES cycles.
  - FIRE:
    - `int_flag`=1, `int_set_pl_pause`=0.
    - `int_pc` = VEC_BASE + `cause`*VEC_STRIDE, 32-bit wrap.
    - -> SERVICE.
  - SERVICE: `in_service`=1. No new entry, no nesting. Edges still accumulate in `pending`. On `iret` -> RETURN.
  - RETURN: `int_flag`=1, `int_pc`=`epc_out`, `in_service`=0 -> IDLE. A further interrupt may enter from IDLE on the next cycle.
- `int_pc` timing: `int_pc` is a register loaded on entry to FIRE/RETURN. It is valid in the `int_flag` cycle and held until the next load, because the consumer samples it one cycle late.
- `iret` outside SERVICE is ignored.
- `int_flag` is never asserted in the same cycle as `int_set_pl_pause`.
- `clr` mid-operation returns to IDLE immediately, with `int_flag`/`int_set_pl_pause` deasserted asynchronously.
- All outputs are registered. There is no combinational path from input to output.

Test Plan:
- Basic entry:
  - Stimulus: mask=8'hFF, `int_enable`=1, rising edge on `irq[2]`, `epc_in`=32'h40.
  - Response: `pending[2]`=1 next cycle. `int_set_pl_pause` high exactly 3 cycles, then a one-cycle `int_flag` with `int_pc`=32'h120, `cause`=2, `epc_out`=32'h40. Then `in_service`=1 and `pending[2]`=0.
- Priority:
  - Stimulus: edges on `irq[5]` and `irq[1]` in the same cycle.
  - Response: `cause`=1 and `int_pc`=32'h110. `pending[5]` stays 1. After `iret`, `irq[5]` is taken with `int_pc`=32'h150.
- Return:
  - Stimulus: in SERVICE, pulse `iret`.
  - Response: next cycle `int_flag`=1, `int_pc`=32'h40, `in_service`=0. `iret` pulsed in IDLE produces no `int_flag`.
- Gating:
  - Stimulus: mask=8'h00 with an edge on `irq[3]`.
  - Response: `pending[3]`=1 but no pause. Writing mask=8'h08 starts the pause the following cycle.
  - Stimulus: holding `branch_pending`=1 or `int_enable`=0.
  - Response: entry is delayed until the blocking input drops.
- Boundaries:
  - Stimulus: edge on `irq[2]` in its own FIRE cycle.
  - Response: `pending[2]` remains 1.
  - Stimulus: `int_enable` dropped mid-PAUSE.
  - Response: the pause still completes and FIRE still occurs.
- Reset mid-PAUSE:
  - Stimulus: assert `clr` asynchronously during PAUSE.
  - Response: `int_set_pl_pause`=0 immediately, FSM in IDLE, `pending`=0.
